// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin front end that shares one iterative divider
// between two requesters. It handles divide-by-zero locally, flags a divider
// that never signals done, and returns each result tagged with its requester id.
module div_share_ctrl #(
  parameter int N        = 24,
  parameter int TO_SLACK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_quotient,
  output logic [N-1:0] resp_remainder,
  output logic         resp_dz,
  output logic         resp_err,
  output logic         div_load,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  input  logic         div_done,
  input  logic [N-1:0] div_quotient,
  input  logic [N-1:0] div_remainder,
  output logic         busy
);

  localparam int CW = $clog2(N + TO_SLACK + 1);
  // Last WAIT count value; the edge that would step past it declares a timeout.
  localparam logic [CW-1:0] TO_LIM  = CW'(N + TO_SLACK - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_rr_ptr;   // requester favoured on a tie (0 = req0)
  logic          r_id;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_dividend, r_divisor;
  logic [N-1:0]  r_quot, r_rem;
  logic          r_dz, r_err;

  logic          w_gnt0, w_gnt1, w_acc, w_acc_id, w_acc_dz, w_timeout;
  logic [N-1:0]  w_sel_dividend, w_sel_divisor;

  // Grant: a lone requester wins; on a tie the favoured one wins.
  always_comb begin
    w_gnt0         = req0_valid & (~req1_valid | ~r_rr_ptr);
    w_gnt1         = req1_valid & (~req0_valid |  r_rr_ptr);
    req0_ready     = (r_state == S_IDLE) & w_gnt0;
    req1_ready     = (r_state == S_IDLE) & w_gnt1;
    w_acc          = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    w_acc_id       = req1_ready;
    w_sel_dividend = w_acc_id ? req1_dividend : req0_dividend;
    w_sel_divisor  = w_acc_id ? req1_divisor  : req0_divisor;
    w_acc_dz       = (w_sel_divisor == '0);
    w_timeout      = (r_cnt == TO_LIM);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = w_acc_dz ? S_RESP : S_LOAD;
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: if (div_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs that are pure functions of the state.
  always_comb begin
    div_load   = (r_state == S_LOAD);
    resp_valid = (r_state == S_RESP);
    busy       = (r_state != S_IDLE);
  end

  // Datapath: operand/id capture, tie-break pointer, timeout counter, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dz       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_dividend <= w_sel_dividend;
          r_divisor  <= w_sel_divisor;
          r_id       <= w_acc_id;
          // Favour the other requester next time there is a tie.
          r_rr_ptr   <= ~w_acc_id;
          if (w_acc_dz) begin
            r_quot <= '1;
            r_rem  <= w_sel_dividend;
            r_dz   <= 1'b1;
            r_err  <= 1'b0;
          end
        end
        S_LOAD: r_cnt <= '0;
        S_WAIT: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (div_done) begin
            r_quot <= div_quotient;
            r_rem  <= div_remainder;
            r_dz   <= 1'b0;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
            r_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_dividend   = r_dividend;
  assign div_divisor    = r_divisor;
  assign resp_id        = r_id;
  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;
  assign resp_dz        = r_dz;
  assign resp_err       = r_err;

endmodule
